// File: rtl/light_pkg.sv
// Shared definitions for the light-stand mode controller: mode encodings,
// the mode type and the default PWM/duty constants.
package light_pkg;

  // Light stand modes in press order; the encoding is visible on o_mode.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_MID  = 2'd2,
    MODE_HIGH = 2'd3
  } mode_t;

  localparam int DEF_PWM_PERIOD      = 1000;
  localparam int DEF_DUTY_LOW        = 250;
  localparam int DEF_DUTY_MID        = 500;
  localparam int DEF_DUTY_HIGH       = 1000;
  localparam int DEF_AUTO_OFF_CYCLES = 100_000_000;

endpackage

// File: rtl/pwm_gen.sv
// Glitch-free PWM generator. A free-running period counter drives a
// registered compare against a shadowed duty. The shadow only loads on the
// last count of a period, so a duty change never disturbs a period already
// in progress.
module pwm_gen #(
  parameter int PWM_PERIOD = 1000,
  localparam int CNT_W     = $clog2(PWM_PERIOD),
  localparam int CMP_W     = $clog2(PWM_PERIOD + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [CMP_W-1:0] i_duty,
  output logic             o_pwm,
  output logic             o_period_start
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic [CMP_W-1:0] duty_active;
  logic [CMP_W-1:0] cnt_ext;
  logic             wrap;

  // Compare width is one wider when needed so a duty equal to the period
  // is representable and gives a constant-high output.
  assign cnt_ext = CMP_W'(cnt);
  assign wrap    = (cnt == CNT_LAST);

  // Period counter, duty shadow and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt            <= '0;
      duty_active    <= '0;
      o_pwm          <= 1'b0;
      o_period_start <= 1'b0;
    end else begin
      cnt            <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        duty_active <= i_duty;
      end
      o_pwm          <= (cnt_ext < duty_active);
      o_period_start <= (cnt == '0);
    end
  end

endmodule

// File: rtl/light_mode_ctrl.sv
// Light-stand mode controller. Edge-detects the debounced press strobe,
// steps OFF -> LOW -> MID -> HIGH -> OFF on each accepted press, selects the
// PWM duty for the current mode and drives the LED through pwm_gen.
// Optional idle auto-off: define LIGHT_AUTO_OFF_EN to return to OFF after
// AUTO_OFF_CYCLES cycles without an accepted press.
//
// Press strobe protocol: i_press has no ready/acknowledge; a press is taken
// on the single cycle where i_press is 1 and was 0 the cycle before, so a
// strobe held high for many cycles counts once. The FSM state is visible
// directly on o_mode.
module light_mode_ctrl
  import light_pkg::*;
#(
  parameter int PWM_PERIOD      = DEF_PWM_PERIOD,
  parameter int DUTY_LOW        = DEF_DUTY_LOW,
  parameter int DUTY_MID        = DEF_DUTY_MID,
  parameter int DUTY_HIGH       = DEF_DUTY_HIGH,
  parameter int AUTO_OFF_CYCLES = DEF_AUTO_OFF_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_press,
  output logic [1:0] o_mode,
  output logic       o_pwm,
  output logic       o_period_start
);

  localparam int CMP_W = $clog2(PWM_PERIOD + 1);

  mode_t            mode_q;
  mode_t            mode_d;
  logic             press_q;
  logic             accept;
  logic             timeout;
  logic [CMP_W-1:0] duty_sel;

  assign accept = i_press & ~press_q;
  assign o_mode = mode_q;

  // Previous-cycle press for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      press_q <= 1'b0;
    end else begin
      press_q <= i_press;
    end
  end

`ifdef LIGHT_AUTO_OFF_EN
  localparam int IDLE_W = $clog2(AUTO_OFF_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(AUTO_OFF_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout = (mode_q != MODE_OFF) && (idle_cnt == IDLE_LAST);

  // Idle counter: runs while lit, cleared by presses, held at 0 in OFF.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idle_cnt <= '0;
    end else if (accept || mode_q == MODE_OFF || timeout) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Mode state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q <= MODE_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next mode: an accepted press steps the cycle and wins over a timeout.
  always_comb begin
    mode_d = mode_q;
    if (accept) begin
      unique case (mode_q)
        MODE_OFF:  mode_d = MODE_LOW;
        MODE_LOW:  mode_d = MODE_MID;
        MODE_MID:  mode_d = MODE_HIGH;
        MODE_HIGH: mode_d = MODE_OFF;
        default:   mode_d = MODE_OFF;
      endcase
    end else if (timeout) begin
      mode_d = MODE_OFF;
    end
  end

  // Duty select from the current mode.
  always_comb begin
    duty_sel = '0;
    unique case (mode_q)
      MODE_OFF:  duty_sel = '0;
      MODE_LOW:  duty_sel = CMP_W'(DUTY_LOW);
      MODE_MID:  duty_sel = CMP_W'(DUTY_MID);
      MODE_HIGH: duty_sel = CMP_W'(DUTY_HIGH);
      default:   duty_sel = '0;
    endcase
  end

  pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm_gen (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_duty         (duty_sel),
    .o_pwm          (o_pwm),
    .o_period_start (o_period_start)
  );

endmodule

// File: tb/tb_light_mode_ctrl.sv
// Directed bench for light_mode_ctrl with PWM_PERIOD=10 and duties 2/5/10.
// Auto-off scenario runs only when LIGHT_AUTO_OFF_EN is defined.
module tb_light_mode_ctrl;

  logic       clk;
  logic       rst;
  logic       press;
  logic [1:0] mode;
  logic       pwm;
  logic       pstart;

  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [31:0] exp_q[$];

  light_mode_ctrl #(
    .PWM_PERIOD      (10),
    .DUTY_LOW        (2),
    .DUTY_MID        (5),
    .DUTY_HIGH       (10),
    .AUTO_OFF_CYCLES (50)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_press        (press),
    .o_mode         (mode),
    .o_pwm          (pwm),
    .o_period_start (pstart)
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_once();
    press = 1'b1;
    tick();
    press = 1'b0;
  endtask

  // Advance until the current sample is the first cycle of a period.
  task automatic wait_period_start();
    int k;
    k = 0;
    while (!pstart && k < 20) begin
      tick();
      k++;
    end
    check_eq("period_start_seen", {31'd0, pstart}, 32'd1);
  endtask

  // Count high cycles over n samples beginning at a period start.
  task automatic measure_highs(input int n, output int hi);
    hi = 0;
    wait_period_start();
    for (int i = 0; i < n; i++) begin
      hi += int'(pwm);
      tick();
    end
  endtask

  initial begin
    int hi;
    int bad;
    int ps_cnt;
    int steps;
    logic [31:0] exp_v;

    rst   = 1'b1;
    press = 1'b0;

    // 1. Reset, then idle in OFF
    ticks(3);
    check_eq("rst_mode", {30'd0, mode}, 32'd0);
    check_eq("rst_pwm", {31'd0, pwm}, 32'd0);
    check_eq("rst_pstart", {31'd0, pstart}, 32'd0);
    rst = 1'b0;
    bad = 0;
    ps_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 0) check_eq("first_pstart_after_rst", {31'd0, pstart}, 32'd1);
      if (mode != 2'd0 || pwm != 1'b0) bad++;
      ps_cnt += int'(pstart);
    end
    check_eq("off_idle_bad_samples", bad, 0);
    check_eq("off_idle_pstart_count", ps_cnt, 3);

    // 2. Four presses: mode 1,2,3,0 with per-period high counts 2,5,10,0
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd0);
    for (int p = 0; p < 4; p++) begin
      press_once();
      check_eq("step_mode", {30'd0, mode}, (p + 1) % 4);
      ticks(12);
      measure_highs(10, hi);
      exp_v = exp_q.pop_front();
      check_eq("step_highs", hi, exp_v);
      ticks(5);
    end
    // HIGH has already been left; confirm continuous high separately below.

    // 3. Held press in OFF advances once
    press = 1'b1;
    tick();
    check_eq("held_first_step", {30'd0, mode}, 32'd1);
    ticks(24);
    check_eq("held_no_more_steps", {30'd0, mode}, 32'd1);
    press = 1'b0;
    tick();
    check_eq("held_release_mode", {30'd0, mode}, 32'd1);

    // 4. In LOW, press when cnt=3: current period keeps 2 highs, next has 5
    wait_period_start();
    hi = int'(pwm);
    tick();
    hi += int'(pwm);
    tick();
    hi += int'(pwm);
    press = 1'b1;
    tick();
    press = 1'b0;
    check_eq("midperiod_mode", {30'd0, mode}, 32'd2);
    for (int i = 3; i < 10; i++) begin
      hi += int'(pwm);
      tick();
    end
    check_eq("midperiod_cur_highs", hi, 2);
    check_eq("midperiod_next_start", {31'd0, pstart}, 32'd1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      hi += int'(pwm);
      tick();
    end
    check_eq("midperiod_next_highs", hi, 5);

    // 6. HIGH: continuous high across wraps, then reset at cnt=6
    press_once();
    check_eq("to_high_mode", {30'd0, mode}, 32'd3);
    ticks(12);
    measure_highs(20, hi);
    check_eq("high_two_periods", hi, 20);
    wait_period_start();
    ticks(5);
    check_eq("high_pwm_before_rst", {31'd0, pwm}, 32'd1);
    rst = 1'b1;
    tick();
    check_eq("midrst_mode", {30'd0, mode}, 32'd0);
    check_eq("midrst_pwm", {31'd0, pwm}, 32'd0);
    check_eq("midrst_pstart", {31'd0, pstart}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_pstart", {31'd0, pstart}, 32'd1);
    check_eq("post_rst_pwm", {31'd0, pwm}, 32'd0);

`ifdef LIGHT_AUTO_OFF_EN
    // 5. Auto-off after 50 idle cycles; press on timeout cycle wins
    ticks(3);
    press_once();
    check_eq("ao_on_mode", {30'd0, mode}, 32'd1);
    steps = 0;
    while (mode != 2'd0 && steps < 100) begin
      tick();
      steps++;
    end
    check_eq("ao_timeout_cycles", steps, 50);
    ticks(3);
    press_once();
    check_eq("ao_on_mode2", {30'd0, mode}, 32'd1);
    ticks(49);
    check_eq("ao_before_timeout", {30'd0, mode}, 32'd1);
    press_once();
    check_eq("ao_press_wins", {30'd0, mode}, 32'd2);
    ticks(10);
    check_eq("ao_stays_mid", {30'd0, mode}, 32'd2);
`else
    steps = 0;
    ticks(3);
    press_once();
    while (mode == 2'd1 && steps < 80) begin
      tick();
      steps++;
    end
    check_eq("no_auto_off", steps, 80);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
